qpsk_demod_axis: RTL and testbench

Hard-decision QPSK demapper for the OFDM receive path. It accepts equalised frequency-domain samples as 32-bit {Q,I} words on AXI-Stream and emits 2-bit symbols in the 6-bit bit-stream format used by the transmit modulator input. It also passes packet and OFDM-symbol boundaries through and checks per-symbol subcarrier count. It sits between the equaliser/subcarrier extractor and the deinterleaver.

---
 rtl/ofdm_pkg.sv | 34 +++
 rtl/axis_skid_buf.sv | 77 +++++++
 rtl/qpsk_demod_axis.sv | 128 ++++++++++++
 tb/tb_qpsk_demod_axis.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM receive/transmit constants: QPSK levels, demapper soft threshold,
// {Q,I} word layout, the buffered beat format and a saturating magnitude helper.
package ofdm_pkg;

    localparam logic [15:0] QPSK_POS        = 16'h5A82;
    localparam logic [15:0] QPSK_NEG        = 16'hA57E;
    localparam logic [15:0] SOFT_THRESH_DEF = 16'h2D41;

    // {Q,I} sample word layout
    localparam int unsigned IQ_W  = 16;
    localparam int unsigned I_LSB = 0;
    localparam int unsigned Q_LSB = 16;

    // One demapped beat as it travels through the skid buffer
    typedef struct packed {
        logic       symb_last;
        logic       last;
        logic [5:0] data;
    } beat_t;

    // |x| with the most negative value clipped to the most positive one
    function automatic logic [15:0] abs_sat(input logic [15:0] x);
        logic [15:0] r;
        if (x == 16'h8000) begin
            r = 16'h7FFF;
        end else if (x[15]) begin
            r = 16'(~x + 16'd1);
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer (output register + skid register).
// Upstream ready is registered and equals "skid empty", so no combinational
// path runs from downstream ready to upstream ready.
module axis_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    input  logic [Width-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [Width-1:0] m_data_o,
    input  logic             m_ready_i
);

    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             ready_q, ready_d;
    logic             in_fire;
    logic             out_free;

    // Next-state: route accepted beats to output or skid, refill output from skid
    always_comb begin
        in_fire      = s_valid_i & ready_q;
        out_free     = ~out_valid_q | m_ready_i;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            if (skid_valid_q) begin
                // Oldest beat first; a new beat (only possible if ready lagged) backfills the skid
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                if (in_fire) begin
                    skid_data_d = s_data_i;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = s_data_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
        ready_d = ~skid_valid_d;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

// File: rtl/qpsk_demod_axis.sv
// Hard-decision QPSK demapper on AXI-Stream with packet/OFDM-symbol sideband
// pass-through and a sticky per-symbol subcarrier count check.
// Build option: define QPSK_DEMOD_SOFT_EN to fill tdata[3:2] with magnitude
// confidence bits (|I|, |Q| >= SOFT_THRESH); otherwise tdata[5:2] is zero.
module qpsk_demod_axis
    import ofdm_pkg::*;
#(
    parameter int unsigned SC_PER_SYMB = 48
`ifdef QPSK_DEMOD_SOFT_EN
    ,
    parameter logic [15:0] SOFT_THRESH = SOFT_THRESH_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    input  logic        s_bit_symb_last,
    output logic        m_axis_tvalid,
    output logic [5:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        m_bit_symb_last,
    output logic        symb_len_err,
    input  logic        err_clr
);

    localparam int unsigned CntW    = (SC_PER_SYMB > 1) ? $clog2(SC_PER_SYMB) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SC_PER_SYMB - 1);
    localparam int unsigned BeatW   = $bits(beat_t);

    logic [IQ_W-1:0] i_val, q_val;
    logic [3:0]      soft_bits;
    beat_t           in_beat, out_beat;
    logic            in_fire;

    logic [CntW-1:0] sc_cnt_q, sc_cnt_d;
    logic            err_q, err_d;
    logic            err_set;

    assign i_val = s_axis_tdata[I_LSB +: IQ_W];
    assign q_val = s_axis_tdata[Q_LSB +: IQ_W];

`ifdef QPSK_DEMOD_SOFT_EN
    logic [IQ_W-1:0] i_mag, q_mag;

    // Confidence bits from saturated magnitudes
    always_comb begin
        i_mag     = abs_sat(i_val);
        q_mag     = abs_sat(q_val);
        soft_bits = {2'b00, (q_mag >= SOFT_THRESH), (i_mag >= SOFT_THRESH)};
    end
`else
    logic unused_iq_mag;

    assign soft_bits     = 4'b0000;
    assign unused_iq_mag = ^{i_val[IQ_W-2:0], q_val[IQ_W-2:0]};
`endif

    // Sign decision: non-negative decides to 1; sidebands ride with the beat
    always_comb begin
        in_beat.symb_last = s_bit_symb_last;
        in_beat.last      = s_axis_tlast;
        in_beat.data      = {soft_bits, ~q_val[IQ_W-1], ~i_val[IQ_W-1]};
    end

    axis_skid_buf #(
        .Width (BeatW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (s_axis_tvalid),
        .s_data_i  (in_beat),
        .s_ready_o (s_axis_tready),
        .m_valid_o (m_axis_tvalid),
        .m_data_o  (out_beat),
        .m_ready_i (m_axis_tready)
    );

    assign in_fire = s_axis_tvalid & s_axis_tready;

    // Subcarrier count check; any framing violation realigns the counter to 0
    always_comb begin
        sc_cnt_d = sc_cnt_q;
        err_set  = 1'b0;
        if (in_fire) begin
            if (s_bit_symb_last) begin
                err_set  = (sc_cnt_q != CntLast);
                sc_cnt_d = '0;
            end else if (sc_cnt_q == CntLast) begin
                err_set  = 1'b1;
                sc_cnt_d = '0;
            end else if (s_axis_tlast) begin
                err_set  = 1'b1;
                sc_cnt_d = '0;
            end else begin
                sc_cnt_d = sc_cnt_q + 1'b1;
            end
        end
        // A new error in the clearing cycle must not be lost
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Counter and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            sc_cnt_q <= sc_cnt_d;
            err_q    <= err_d;
        end
    end

    assign m_axis_tdata    = out_beat.data;
    assign m_axis_tlast    = out_beat.last;
    assign m_bit_symb_last = out_beat.symb_last;
    assign symb_len_err    = err_q;

endmodule

// File: tb/tb_qpsk_demod_axis.sv
// Directed self-checking bench for qpsk_demod_axis.
module tb_qpsk_demod_axis;
    import ofdm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        s_bit_symb_last = 1'b0;
    logic        m_axis_tvalid;
    logic [5:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        m_bit_symb_last;
    logic        symb_len_err;
    logic        err_clr = 1'b0;

`ifdef QPSK_DEMOD_SOFT_EN
    localparam logic [3:0] SoftBoth = 4'b0011;
    localparam logic [3:0] SoftQ    = 4'b0010;
    localparam logic [3:0] SoftI    = 4'b0001;
`else
    localparam logic [3:0] SoftBoth = 4'b0000;
    localparam logic [3:0] SoftQ    = 4'b0000;
    localparam logic [3:0] SoftI    = 4'b0000;
`endif

    int total = 0;
    int bad   = 0;
    int stall_cnt = 0;
    logic [7:0] got_q[$];

    qpsk_demod_axis dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .s_bit_symb_last (s_bit_symb_last),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .m_bit_symb_last (m_bit_symb_last),
        .symb_len_err    (symb_len_err),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    // Record every output handshake as {symb_last, tlast, tdata}
    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_bit_symb_last, m_axis_tlast, m_axis_tdata});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time exceeded, got running want finished");
        $fatal(1);
    end

    // Present one beat and hold it until accepted (bounded)
    task automatic push(input logic [15:0] q, input logic [15:0] i, input logic tl,
                        input logic sl);
        int waits;
        @(negedge clk);
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = {q, i};
        s_axis_tlast    = tl;
        s_bit_symb_last = sl;
        waits = 0;
        while (!s_axis_tready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        stall_cnt += waits;
        total++;
        if (!s_axis_tready) begin
            bad++;
            $display("FAIL push_accept: ready=%0b after %0d cycles, want 1", s_axis_tready, waits);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        s_bit_symb_last = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_bit_symb_last,
             symb_len_err} !== 11'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {s_axis_tready, m_axis_tvalid,
                     m_axis_tdata, m_axis_tlast, m_bit_symb_last, symb_len_err});
        end
        rst = 1'b1;
        #1;
        total++;
        if (s_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: got %b want 0", s_axis_tready);
        end
        @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge: got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_single_beat();
        m_axis_tready = 1'b1;
        got_q.delete();
        push(QPSK_POS, QPSK_NEG, 1'b1, 1'b0);
        idle();
        total++;
        if ({m_axis_tvalid, m_axis_tdata[1:0], m_axis_tlast} !== 4'b1101) begin
            bad++;
            $display("FAIL single_out: got v/bits/last %b want 1101",
                     {m_axis_tvalid, m_axis_tdata[1:0], m_axis_tlast});
        end
        // A one-beat packet is a short symbol
        total++;
        if (symb_len_err !== 1'b1) begin
            bad++;
            $display("FAIL single_err: got %b want 1", symb_len_err);
        end
        @(negedge clk);
        total++;
        if (got_q.size() != 1 || got_q[0] !== {2'b01, SoftBoth, 2'b10}) begin
            bad++;
            $display("FAIL single_capture: got n=%0d first=%h want n=1 %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx, {2'b01, SoftBoth, 2'b10});
        end
        clear_err();
        total++;
        if (symb_len_err !== 1'b0) begin
            bad++;
            $display("FAIL single_clr: got %b want 0", symb_len_err);
        end
    endtask

    task automatic test_full_symbol();
        logic [7:0] exp;
        int errs;
        got_q.delete();
        stall_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            push(k[1] ? QPSK_POS : QPSK_NEG, k[0] ? QPSK_POS : QPSK_NEG, k == 47, k == 47);
        end
        idle();
        @(negedge clk);
        total++;
        if (stall_cnt != 0) begin
            bad++;
            $display("FAIL full_throughput: got %0d stalls want 0", stall_cnt);
        end
        total++;
        if (got_q.size() != 48) begin
            bad++;
            $display("FAIL full_count: got %0d want 48", got_q.size());
        end else begin
            errs = 0;
            for (int k = 0; k < 48; k++) begin
                exp = {k == 47, k == 47, SoftBoth, k[1], k[0]};
                if (got_q[k] !== exp) begin
                    errs++;
                    $display("FAIL full_beat%0d: got %h want %h", k, got_q[k], exp);
                end
            end
            if (errs != 0) bad++;
        end
        total++;
        if (symb_len_err !== 1'b0) begin
            bad++;
            $display("FAIL full_err: got %b want 0", symb_len_err);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
        exp[0] = {2'b00, SoftBoth, 2'b00};
        exp[1] = {2'b00, SoftBoth, 2'b01};
        exp[2] = {2'b00, SoftBoth, 2'b10};
        exp[3] = {2'b11, SoftBoth, 2'b11};
        got_q.delete();
        m_axis_tready = 1'b1;
        push(QPSK_NEG, QPSK_NEG, 1'b0, 1'b0);
        @(negedge clk);
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        push(QPSK_NEG, QPSK_POS, 1'b0, 1'b0);
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {QPSK_POS, QPSK_NEG};
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if ({s_axis_tready, m_axis_tvalid, m_axis_tdata} !== {2'b01, exp[0][5:0]}) begin
                bad++;
                $display("FAIL bp_hold%0d: got rdy/v/data %b/%b/%h want 0/1/%h", c,
                         s_axis_tready, m_axis_tvalid, m_axis_tdata, exp[0][5:0]);
            end
        end
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL bp_no_output: got %0d beats want 0", got_q.size());
        end
        m_axis_tready = 1'b1;
        push(QPSK_POS, QPSK_NEG, 1'b0, 1'b0);
        push(QPSK_POS, QPSK_POS, 1'b1, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL bp_count: got %0d want 4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got_q[k] !== exp[k]) begin
                    bad++;
                    $display("FAIL bp_order%0d: got %h want %h", k, got_q[k], exp[k]);
                end
            end
        end
        // Four-beat symbol is short
        total++;
        if (symb_len_err !== 1'b1) begin
            bad++;
            $display("FAIL bp_err: got %b want 1", symb_len_err);
        end
        clear_err();
    endtask

    task automatic test_len_err();
        got_q.delete();
        for (int k = 0; k < 39; k++) push(QPSK_POS, QPSK_POS, 1'b0, 1'b0);
        idle();
        total++;
        if (symb_len_err !== 1'b0) begin
            bad++;
            $display("FAIL len_pre: got %b want 0", symb_len_err);
        end
        push(QPSK_POS, QPSK_POS, 1'b1, 1'b1);
        idle();
        total++;
        if (symb_len_err !== 1'b1) begin
            bad++;
            $display("FAIL len_short: got %b want 1", symb_len_err);
        end
        clear_err();
        total++;
        if (symb_len_err !== 1'b0 || got_q.size() != 40 || got_q[39] !== {2'b11, SoftBoth, 2'b11})
        begin
            bad++;
            $display("FAIL len_clr: got err=%b n=%0d want err=0 n=40", symb_len_err, got_q.size());
        end
        // 48 beats without a symbol marker: error on the wrap
        for (int k = 0; k < 47; k++) push(QPSK_NEG, QPSK_POS, 1'b0, 1'b0);
        idle();
        total++;
        if (symb_len_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap_pre: got %b want 0", symb_len_err);
        end
        push(QPSK_NEG, QPSK_POS, 1'b0, 1'b0);
        idle();
        total++;
        if (symb_len_err !== 1'b1) begin
            bad++;
            $display("FAIL wrap_err: got %b want 1", symb_len_err);
        end
        clear_err();
        // Error set in the clearing cycle wins
        @(negedge clk);
        total++;
        if ({s_axis_tready, symb_len_err} !== 2'b10) begin
            bad++;
            $display("FAIL collide_pre: got rdy/err %b want 10", {s_axis_tready, symb_len_err});
        end
        err_clr         = 1'b1;
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = {QPSK_POS, QPSK_POS};
        s_axis_tlast    = 1'b1;
        s_bit_symb_last = 1'b0;
        @(negedge clk);
        err_clr         = 1'b0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        total++;
        if (symb_len_err !== 1'b1) begin
            bad++;
            $display("FAIL collide_err: got %b want 1", symb_len_err);
        end
        clear_err();
        total++;
        if (symb_len_err !== 1'b0) begin
            bad++;
            $display("FAIL collide_clr: got %b want 0", symb_len_err);
        end
    endtask

    task automatic test_soft();
        logic [7:0] exp [3];
        exp[0] = {2'b00, SoftQ, 2'b01};
        exp[1] = {2'b00, SoftI, 2'b11};
        exp[2] = {2'b11, SoftI, 2'b00};
        got_q.delete();
        push(16'h8000, 16'h0000, 1'b0, 1'b0);
        push(16'h2D40, 16'h2D41, 1'b0, 1'b0);
        push(16'hD2C0, 16'hD2BF, 1'b1, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        total++;
        if (got_q.size() != 3) begin
            bad++;
            $display("FAIL soft_count: got %0d want 3", got_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (got_q[k] !== exp[k]) begin
                    bad++;
                    $display("FAIL soft_beat%0d: got %h want %h", k, got_q[k], exp[k]);
                end
            end
        end
        clear_err();
    endtask

    task automatic test_reset_midstream();
        m_axis_tready = 1'b0;
        got_q.delete();
        push(QPSK_POS, QPSK_POS, 1'b1, 1'b0);
        push(QPSK_NEG, QPSK_NEG, 1'b0, 1'b0);
        idle();
        total++;
        if ({s_axis_tready, m_axis_tvalid, symb_len_err} !== 3'b011) begin
            bad++;
            $display("FAIL rstm_pre: got rdy/v/err %b want 011",
                     {s_axis_tready, m_axis_tvalid, symb_len_err});
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_bit_symb_last,
             symb_len_err} !== 11'b0) begin
            bad++;
            $display("FAIL rstm_async: got %b want 0", {s_axis_tready, m_axis_tvalid,
                     m_axis_tdata, m_axis_tlast, m_bit_symb_last, symb_len_err});
        end
        @(negedge clk);
        rst = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        push(QPSK_POS, QPSK_NEG, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        total++;
        if (got_q.size() != 1 || got_q[0] !== {2'b11, SoftBoth, 2'b10}) begin
            bad++;
            $display("FAIL rstm_next: got n=%0d first=%h want n=1 %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx, {2'b11, SoftBoth, 2'b10});
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_full_symbol();
        test_backpressure();
        test_len_err();
        test_soft();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
